// File: rtl/arb_rrb_oht.sv
// rtl/arb_rrb_oht.sv - round-robin packet arbiter with one-hot grant driving a one-hot mux
//
// mux_oht: one-hot selector.
//   sel  : one-hot (or zero) select
//   din  : WIDTH data inputs
//   dout : selected data, zero when sel is zero
//
// arb_rrb_oht: shares one output stream between WIDTH requesters; grant is held
// from the first presented beat until the last beat of the packet transfers.
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_vld, req_lst, req_dat : per-requester beat valid / last flag / data
//   req_rdy                   : per-requester ready (gnt & out_rdy)
//   out_vld, out_lst, out_dat : shared output beat
//   out_rdy                   : shared output ready
//   gnt                       : one-hot (or zero) grant
//   lck                       : grant locked to a packet in progress

module mux_oht #(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 16,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] sel,
    input  DAT_T [WIDTH-1:0] din,
    output DAT_T             dout
);
    generate
        if (IMPLEMENTATION == 0) begin : g_and_or
            // AND-OR tree: no encoder, relies on sel being one-hot.
            always_comb begin
                dout = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (sel[i]) dout = dout | din[i];
                end
            end
        end else begin : g_encoded
            localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
            logic [IW-1:0] idx;
            logic          any;
            always_comb begin
                idx = '0;
                any = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (sel[i]) begin
                        idx = IW'(i);
                        any = 1'b1;
                    end
                end
                dout = any ? din[idx] : '0;
            end
        end
    endgenerate
endmodule

module arb_rrb_oht #(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 16,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_vld,
    input  logic [WIDTH-1:0] req_lst,
    input  DAT_T [WIDTH-1:0] req_dat,
    output logic [WIDTH-1:0] req_rdy,
    output logic             out_vld,
    output logic             out_lst,
    output DAT_T             out_dat,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] gnt,
    output logic             lck
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] gnt_q;

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] gnt_int;
    logic             vld_int;
    logic             lst_int;
    logic             xfer;

    // Circular priority search: first look at requesters at or above the
    // pointer position; if none, wrap and take the lowest requester overall.
    // x & -x isolates the lowest set bit.
    always_comb begin
        masked = req_vld & ~(ptr - WIDTH'(1));
        if (|masked) cand = masked & (~masked + WIDTH'(1));
        else         cand = req_vld & (~req_vld + WIDTH'(1));
        gnt_int = (state == LOCK) ? gnt_q : cand;
        vld_int = |(gnt_int & req_vld);
        lst_int = |(gnt_int & req_lst);
        xfer    = vld_int & out_rdy;
    end

    mux_oht #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_mux (
        .sel  (gnt_int),
        .din  (req_dat),
        .dout (out_dat)
    );

    // Control outputs are gated by rst_n so they read zero while reset is held.
    assign gnt     = rst_n ? gnt_int : '0;
    assign req_rdy = gnt & {WIDTH{out_rdy}};
    assign out_vld = rst_n & vld_int;
    assign out_lst = rst_n & lst_int;
    assign lck     = rst_n & (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= WIDTH'(1);
            gnt_q <= '0;
        end else if (xfer && lst_int) begin
            // Winner moves to lowest priority: pointer goes one past it.
            state <= IDLE;
            ptr   <= {gnt_int[WIDTH-2:0], gnt_int[WIDTH-1]};
            gnt_q <= '0;
        end else if (state == IDLE && vld_int) begin
            state <= LOCK;
            gnt_q <= gnt_int;
        end
    end
endmodule

// File: doc/arb_rrb_oht.md
# arb_rrb_oht

Round-robin packet arbiter that shares one output stream between `WIDTH` requesters. Arbitration produces a one-hot grant. The grant drives an internal `mux_oht` instance that steers the winning requester's data onto the shared output. The grant is locked from the first presented beat until the beat flagged last is transferred. The block sits in front of any shared sink (bus, FIFO, serializer) and is the sequencing controller for the one-hot multiplexer datapath.

## Interface

Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `DAT_T`, default `logic [8-1:0]`: data type of each beat.
- `WIDTH`, default 16: number of requesters. Must be at least 2.
- `IMPLEMENTATION`, default 0: passed unchanged to the internal `mux_oht`.

Ports:
- `clk`  input  1  clock. All state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req_vld`  input  `WIDTH`  per-requester beat valid.
- `req_lst`  input  `WIDTH`  per-requester last-beat-of-packet flag.
- `req_dat`  input  `DAT_T [WIDTH-1:0]`  per-requester beat data.
- `req_rdy`  output  `WIDTH`  per-requester ready, equal to `gnt & {WIDTH{out_rdy}}`.
- `out_vld`  output  1  output beat valid.
- `out_lst`  output  1  output last flag.
- `out_dat`  output  `DAT_T`  output beat data.
- `out_rdy`  input  1  output sink ready.
- `gnt`  output  `WIDTH`  one-hot (or zero) grant.
- `lck`  output  1  grant is locked (state LOCK).

## Operation

Registered state:
- `state`: IDLE or LOCK.
- `ptr`: one-hot priority pointer.
- `gnt_q`: locked grant.

Reset values: `state`=IDLE, `ptr`=`WIDTH'(1)`, `gnt_q`=0.

While `rst_n`=0 the following outputs are forced low: `gnt`, `req_rdy`, `out_vld`, `out_lst`, `lck`. `out_dat` is don't-care.

Grant:
- In IDLE, `gnt` is the combinational candidate: the first set bit of `req_vld` scanning upward from the `ptr` bit position, wrapping from `WIDTH-1` to 0. If no `req_vld` bit is set, `gnt` is 0.
- In LOCK, `gnt` = `gnt_q`. New requests are ignored.

Outputs:
- `out_vld` = |(`gnt & req_vld`).
- `out_lst` = |(`gnt & req_lst`).
- `out_dat` = `mux_oht(gnt, req_dat)`.
- `lck` = (`state` == LOCK).
- Transfer `xfer` = `out_vld & out_rdy`.

Transitions:
- IDLE or LOCK, `xfer & out_lst`: next state IDLE; `ptr` <= `gnt` rotated left by 1, so bit `WIDTH-1` wraps to bit 0; `gnt_q` <= 0.
- IDLE, `out_vld` and not (`xfer & out_lst`): next state LOCK; `gnt_q` <= `gnt`.
- LOCK otherwise: stay in LOCK. The grant is held even if the granted `req_vld` drops between beats; `out_vld` is then 0 and no other requester is served.
- IDLE with `out_vld`=0: stay in IDLE; `ptr` unchanged.

Requester protocol:
- A requester must hold `req_vld`, `req_lst` and `req_dat` stable until its `req_rdy` is seen.
- Gaps between beats are allowed.

Fairness: a continuously requesting source waits at most `WIDTH-1` packets.

## Timing

- Request-to-output latency is zero cycles: `req_*` to `out_*` is combinational through the arbiter and the mux.
- Ready is combinational: `out_rdy` to `req_rdy`.
- Single-beat packets (`req_lst`=1) from different requesters can transfer on consecutive cycles, one per cycle. There is no arbitration bubble.
- The pointer update takes effect on the cycle after the last-beat transfer.
- The grant is stable from the first cycle `out_vld`=1 through the cycle of the last-beat transfer, even if `out_rdy`=0 for any number of cycles.
- Reset asserted mid-packet aborts the packet immediately. After release the block is in IDLE, `ptr` is at index 0, and arbitration starts fresh.

## Test plan

1. Reset with `req_vld`=0xFFFF and `out_rdy`=1: all outputs are 0 during reset. On the first cycle after release, `gnt`=0x0001 and `out_dat`=0.
2. All 16 requesters valid, `req_dat[i]`=i, `req_lst`=0xFFFF, `out_rdy`=1: transfers occur on consecutive cycles with `out_dat` = 0,1,…,15,0, and `gnt` walks from 0x0001 to 0x8000 and back to 0x0001.
3. Backpressure: `req_vld`=0x0008 with `out_rdy`=0 for 3 cycles, then requester 5 is raised: `gnt` stays 0x0008, `out_dat`=3 and `lck`=1. Once `out_rdy`=1 and the last beat transfers, `gnt`=0x0020.
4. Packet lock: requester 2 sends a 4-beat packet with a 1-cycle `req_vld` gap after beat 2, while requesters 1 and 7 are valid: all 4 beats come from requester 2, then requester 7, then requester 1.
5. Pointer wrap: a last-beat transfer from requester 15 with requesters 0 and 14 valid: the next grant is 0x0001.
6. Reset mid-packet: `rst_n` is pulsed low after beat 1 of a 3-beat packet from requester 4 while requester 0 is valid. After release `lck`=0 and `gnt`=0x0001.
